// File: rtl/fan_pkg.sv
// Shared types and defaults for the two-stage lead/lag fan sequencer.
package fan_pkg;

  localparam int unsigned DEF_DEB_CYCLES = 4;
  localparam int unsigned DEF_MIN_ON     = 20;
  localparam int unsigned DEF_STAGE_DLY  = 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LEAD  = 2'd1;
  localparam logic [1:0] S_STAGE = 2'd2;
  localparam logic [1:0] S_BOTH  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = S_IDLE,
    LEAD  = S_LEAD,
    STAGE = S_STAGE,
    BOTH  = S_BOTH
  } fan_state_e;

  typedef logic [1:0] demand_t;

  localparam demand_t DEM_NONE = 2'd0;
  localparam demand_t DEM_LOW  = 2'd1;
  localparam demand_t DEM_HIGH = 2'd2;

  // temp38 alone still asks for full cooling; a dead 36 C sensor must not starve the fans
  function automatic demand_t demand_of(input logic t36, input logic t38);
    if (t38) return DEM_HIGH;
    if (t36) return DEM_LOW;
    return DEM_NONE;
  endfunction

  function automatic int unsigned sat_dec(input int unsigned v);
    return (v == 0) ? 0 : v - 1;
  endfunction

endpackage

// File: rtl/fan_debounce.sv
// Two-flop synchronizer followed by a consecutive-sample debouncer for one sensor line.
module fan_debounce
  import fan_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int unsigned CW = $clog2(DEB_CYCLES) + 1;

  logic          meta;
  logic          sync;
  logic [CW-1:0] cnt;

  // cnt tracks how many consecutive synchronized samples disagree with dout
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
      cnt  <= '0;
      dout <= 1'b0;
    end else begin
      meta <= din;
      sync <= meta;
      if (sync == dout) begin
        cnt <= '0;
      end else if (cnt >= CW'(DEB_CYCLES - 1)) begin
        dout <= sync;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/fan_sequencer.sv
// Lead/lag fan sequencer with min-on hold and staged lag start.
// Define FAN_ROTATE_EN to alternate the lead fan on every LEAD->IDLE transition.
module fan_sequencer
  import fan_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int unsigned MIN_ON     = DEF_MIN_ON,
  parameter int unsigned STAGE_DLY  = DEF_STAGE_DLY
) (
  input  logic clk,
  input  logic rst,
  input  logic temp36,
  input  logic temp38,
  output logic fan1,
  output logic fan2,
  output logic lead_sel,
  output logic sensor_err
);

  localparam int unsigned MCW = $clog2(MIN_ON) + 1;
  localparam int unsigned SCW = $clog2(STAGE_DLY) + 1;

`ifdef FAN_ROTATE_EN
  localparam logic ROTATE_EN = 1'b1;
`else
  localparam logic ROTATE_EN = 1'b0;
`endif

  logic t36;
  logic t38;

  fan_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb36 (
    .clk  (clk),
    .rst  (rst),
    .din  (temp36),
    .dout (t36)
  );

  fan_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb38 (
    .clk  (clk),
    .rst  (rst),
    .din  (temp38),
    .dout (t38)
  );

  fan_state_e     state;
  fan_state_e     state_d;
  demand_t        demand_c;
  logic [MCW-1:0] lead_cnt;
  logic [MCW-1:0] lead_cnt_d;
  logic [MCW-1:0] lag_cnt;
  logic [MCW-1:0] lag_cnt_d;
  logic [SCW-1:0] stage_cnt;
  logic [SCW-1:0] stage_cnt_d;
  logic           lead_sel_d;
  logic           lead_on_d;
  logic           lag_on_d;

  assign demand_c = demand_of(t36, t38);

  // A counter at 1 reaches 0 on this edge, so the switch-off lands exactly on expiry
  always_comb begin
    state_d     = state;
    lead_cnt_d  = MCW'(sat_dec(32'(lead_cnt)));
    lag_cnt_d   = MCW'(sat_dec(32'(lag_cnt)));
    stage_cnt_d = SCW'(sat_dec(32'(stage_cnt)));
    lead_sel_d  = lead_sel;

    case (state)
      IDLE: begin
        if (demand_c != DEM_NONE) begin
          state_d    = LEAD;
          lead_cnt_d = MCW'(MIN_ON);
        end
      end
      LEAD: begin
        if (demand_c == DEM_HIGH) begin
          state_d     = STAGE;
          stage_cnt_d = SCW'(STAGE_DLY);
        end else if (demand_c == DEM_NONE && lead_cnt <= MCW'(1)) begin
          state_d    = IDLE;
          lead_sel_d = lead_sel ^ ROTATE_EN;
        end
      end
      STAGE: begin
        if (demand_c != DEM_HIGH) begin
          state_d = LEAD;
        end else if (stage_cnt <= SCW'(1)) begin
          state_d   = BOTH;
          lag_cnt_d = MCW'(MIN_ON);
        end
      end
      BOTH: begin
        if (demand_c != DEM_HIGH && lag_cnt <= MCW'(1)) begin
          state_d = LEAD;
        end
      end
      default: state_d = IDLE;
    endcase

    lead_on_d = (state_d != IDLE);
    lag_on_d  = (state_d == BOTH);
  end

  // Fans are registered from the next state so they move on the same edge as the FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      lead_cnt   <= '0;
      lag_cnt    <= '0;
      stage_cnt  <= '0;
      lead_sel   <= 1'b0;
      fan1       <= 1'b0;
      fan2       <= 1'b0;
      sensor_err <= 1'b0;
    end else begin
      state      <= state_d;
      lead_cnt   <= lead_cnt_d;
      lag_cnt    <= lag_cnt_d;
      stage_cnt  <= stage_cnt_d;
      lead_sel   <= lead_sel_d;
      fan1       <= lead_sel ? lag_on_d  : lead_on_d;
      fan2       <= lead_sel ? lead_on_d : lag_on_d;
      sensor_err <= sensor_err | (t38 & ~t36);
    end
  end

endmodule

// File: tb/tb_fan_sequencer.sv
// Self-checking bench for fan_sequencer (DEB_CYCLES=4, MIN_ON=20, STAGE_DLY=8).
module tb_fan_sequencer;

`ifdef FAN_ROTATE_EN
  localparam logic ROT = 1'b1;
`else
  localparam logic ROT = 1'b0;
`endif

  logic clk;
  logic rst;
  logic temp36;
  logic temp38;
  logic fan1;
  logic fan2;
  logic lead_sel;
  logic sensor_err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  fan_sequencer #(.DEB_CYCLES(4), .MIN_ON(20), .STAGE_DLY(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .temp36     (temp36),
    .temp38     (temp38),
    .fan1       (fan1),
    .fan2       (fan2),
    .lead_sel   (lead_sel),
    .sensor_err (sensor_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic  t36;
    logic  t38;
    int    hold;
    logic  f1;
    logic  f2;
    logic  ls;
    logic  err;
    string name;
  } vec_t;

  typedef struct {
    logic  f1;
    logic  f2;
    logic  ls;
    logic  err;
    string name;
  } exp_t;

  vec_t vecs[11];
  exp_t sbq[$];

  task automatic check(input string name, input logic act, input logic exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  // The two fans must never switch on at the same edge
  logic p1 = 1'b0;
  logic p2 = 1'b0;
  always @(negedge clk) begin
    if ((fan1 && !p1) || (fan2 && !p2)) begin
      total_cnt++;
      if (fan1 && !p1 && fan2 && !p2)
        $display("FAIL both_rise: fan1 and fan2 rose together at %0t", $time);
      else
        pass_cnt++;
    end
    p1 = fan1;
    p2 = fan2;
  end

  task automatic do_reset();
    @(negedge clk);
    rst    = 1'b0;
    temp36 = 1'b0;
    temp38 = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_fan1", fan1, 1'b0);
    check("rst_fan2", fan2, 1'b0);
    check("rst_lead", lead_sel, 1'b0);
    check("rst_err", sensor_err, 1'b0);
    rst = 1'b1;
  endtask

  initial begin
    exp_t e;
    rst    = 1'b0;
    temp36 = 1'b0;
    temp38 = 1'b0;

    vecs[0]  = '{1'b0, 1'b0, 10, 1'b0, 1'b0, 1'b0,      1'b0, "idle"};
    vecs[1]  = '{1'b1, 1'b0,  2, 1'b0, 1'b0, 1'b0,      1'b0, "pulse_on"};
    vecs[2]  = '{1'b0, 1'b0, 15, 1'b0, 1'b0, 1'b0,      1'b0, "pulse_ignored"};
    vecs[3]  = '{1'b1, 1'b0, 10, 1'b1, 1'b0, 1'b0,      1'b0, "lead1_on"};
    vecs[4]  = '{1'b0, 1'b0, 30, 1'b0, 1'b0, ROT,       1'b0, "lead1_off"};
    vecs[5]  = '{1'b1, 1'b0, 10, ~ROT, ROT,  ROT,       1'b0, "lead2_on"};
    vecs[6]  = '{1'b0, 1'b0, 30, 1'b0, 1'b0, 1'b0,      1'b0, "lead2_off"};
    vecs[7]  = '{1'b1, 1'b1, 20, 1'b1, 1'b1, 1'b0,      1'b0, "both_rise"};
    vecs[8]  = '{1'b0, 1'b0, 40, 1'b0, 1'b0, ROT,       1'b0, "both_off"};
    vecs[9]  = '{1'b0, 1'b1, 20, 1'b1, 1'b1, ROT,       1'b1, "err_set"};
    vecs[10] = '{1'b0, 1'b0, 40, 1'b0, 1'b0, 1'b0,      1'b1, "err_sticky"};

    do_reset();

    for (int i = 0; i < 11; i++) begin
      temp36 = vecs[i].t36;
      temp38 = vecs[i].t38;
      sbq.push_back('{vecs[i].f1, vecs[i].f2, vecs[i].ls, vecs[i].err, vecs[i].name});
      repeat (vecs[i].hold) @(negedge clk);
      e = sbq.pop_front();
      check({e.name, "_fan1"}, fan1, e.f1);
      check({e.name, "_fan2"}, fan2, e.f2);
      check({e.name, "_lead"}, lead_sel, e.ls);
      check({e.name, "_err"}, sensor_err, e.err);
    end

    // Input edge to fan-on latency, then min-on hold after a short demand
    do_reset();
    temp36 = 1'b1;
    repeat (6) @(negedge clk);
    check("lat_before", fan1, 1'b0);
    @(negedge clk);
    check("lat_on", fan1, 1'b1);
    repeat (5) @(negedge clk);
    temp36 = 1'b0;
    repeat (14) @(negedge clk);
    check("minon_hold", fan1, 1'b1);
    @(negedge clk);
    check("minon_off", fan1, 1'b0);

    // Stage delay and lag min-on
    do_reset();
    temp36 = 1'b1;
    repeat (7) @(negedge clk);
    check("stg_lead_on", fan1, 1'b1);
    temp38 = 1'b1;
    repeat (14) @(negedge clk);
    check("stg_lag_wait", fan2, 1'b0);
    check("stg_lead_hold", fan1, 1'b1);
    @(negedge clk);
    check("stg_lag_on", fan2, 1'b1);
    temp38 = 1'b0;
    repeat (19) @(negedge clk);
    check("lag_minon_hold", fan2, 1'b1);
    @(negedge clk);
    check("lag_off", fan2, 1'b0);
    check("lag_off_lead", fan1, 1'b1);
    check("no_err", sensor_err, 1'b0);

    // Asynchronous reset while both fans run
    temp38 = 1'b1;
    repeat (25) @(negedge clk);
    check("pre_rst_fan1", fan1, 1'b1);
    check("pre_rst_fan2", fan2, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check("async_fan1", fan1, 1'b0);
    check("async_fan2", fan2, 1'b0);
    check("async_lead", lead_sel, 1'b0);
    check("async_err", sensor_err, 1'b0);

    // After release the inputs must be debounced again before any fan starts
    @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    check("rel_before", fan1, 1'b0);
    @(negedge clk);
    check("rel_on", fan1, 1'b1);
    check("rel_lag_off", fan2, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
